// File: rtl/ddr3_wr_pkg.sv
// Shared definitions for the DDR3 write burst master: FSM states,
// AMM burstcount width and the region address-wrap helper.
package ddr3_wr_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } wr_state_e;

  localparam int BURSTCOUNT_W = 7;

  // Next burst start address; the region end folds back to its base.
  // Address arithmetic is done in 32 bits, which covers any ADDR_W <= 32.
  function automatic logic [31:0] wrap_addr(
    input logic [31:0] addr,
    input logic [31:0] len,
    input logic [31:0] base,
    input logic [31:0] region
  );
    logic [31:0] nxt;
    nxt = addr + len;
    if (nxt >= base + region) begin
      return base;
    end else begin
      return nxt;
    end
  endfunction

endpackage

// File: rtl/ddr3_wr_fifo.sv
// Synchronous show-ahead FIFO with registered full/empty flags and an
// occupancy count; the head word is always visible on dout.
module ddr3_wr_fifo #(
  parameter int WIDTH = 320,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r, count_nxt_s;
  logic             full_r, empty_r, push_s, pop_s;

  assign push_s = push & ~full_r;
  assign pop_s  = pop & ~empty_r;
  assign dout   = mem_r[rd_ptr_r];
  assign full   = full_r;
  assign empty  = empty_r;
  assign count  = count_r;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage array; contents need no reset because empty_r guards reads.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, count and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_W'(DEPTH));
      empty_r <= (count_nxt_s == CNT_W'(0));
    end
  end

endmodule

// File: rtl/ddr3_wr_burst_master.sv
// DDR3 write burst master: buffers a beat stream and issues AMM write bursts
// over a wrapping region. Define DDR3_WR_BURST_STATS_EN for burst/beat counters.
module ddr3_wr_burst_master
  import ddr3_wr_pkg::*;
#(
  parameter int DATA_W       = 320,
  parameter int ADDR_W       = 23,
  parameter int BURST_LEN    = 32,
  parameter int FIFO_DEPTH   = 64,
  parameter int BASE_ADDR    = 0,
  parameter int REGION_WORDS = 1048576
) (
  input  logic                    emif_usr_clk,
  input  logic                    emif_usr_reset_n,
  input  logic [DATA_W-1:0]       s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    flush,
  output logic                    flush_done,
  output logic                    busy,
  input  logic                    amm_ready,
  output logic                    amm_write,
  output logic [ADDR_W-1:0]       amm_address,
  output logic [DATA_W-1:0]       amm_writedata,
  output logic [BURSTCOUNT_W-1:0] amm_burstcount,
`ifdef DDR3_WR_BURST_STATS_EN
  output logic [31:0]             burst_cnt,
  output logic [31:0]             beat_cnt,
`endif
  output logic [DATA_W/8-1:0]     amm_byteenable
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  wr_state_e                state_r, state_nxt_s;
  logic [CNT_W-1:0]         fifo_count_s;
  logic                     fifo_full_s, fifo_empty_s;
  logic [DATA_W-1:0]        fifo_dout_s;
  logic                     push_s, pop_s, start_s, last_s, flush_done_s;
  logic                     ready_en_r, flush_pend_r;
  logic [ADDR_W-1:0]        addr_r;
  logic [BURSTCOUNT_W-1:0]  bcount_r, beats_left_r;
  logic [31:0]              remain_s, cap_s, len_s, count32_s;

  ddr3_wr_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (emif_usr_clk),
    .rst_n (emif_usr_reset_n),
    .push  (push_s),
    .din   (s_data),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // ready_en_r keeps s_ready low until the first clock after reset release.
  assign s_ready      = ready_en_r & ~fifo_full_s & ~flush_pend_r;
  assign push_s       = s_valid & s_ready;
  assign pop_s        = amm_write & amm_ready;
  assign last_s       = pop_s & (beats_left_r == BURSTCOUNT_W'(1));
  assign flush_done_s = (state_r == ST_IDLE) & fifo_empty_s & flush_pend_r;

  // Burst length: capped by the region end, and by the backlog only when flushing.
  assign count32_s = 32'(fifo_count_s);
  assign remain_s  = 32'(BASE_ADDR) + 32'(REGION_WORDS) - 32'(addr_r);
  assign cap_s     = (remain_s < 32'(BURST_LEN)) ? remain_s : 32'(BURST_LEN);
  assign len_s     = (flush_pend_r && (count32_s < cap_s)) ? count32_s : cap_s;
  assign start_s   = (fifo_count_s != CNT_W'(0)) && (count32_s >= len_s);

  assign amm_write      = (state_r == ST_BURST);
  assign amm_address    = addr_r;
  assign amm_burstcount = bcount_r;
  assign amm_writedata  = fifo_dout_s;
  assign amm_byteenable = '1;
  assign busy           = amm_write | ~fifo_empty_s;
  assign flush_done     = flush_done_s;

  // FSM state register.
  always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
    if (!emif_usr_reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: the forced IDLE after each burst gives the inter-burst gap.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_nxt_s = ST_BURST;
        else         state_nxt_s = ST_IDLE;
      end
      ST_BURST: begin
        if (last_s) state_nxt_s = ST_IDLE;
        else        state_nxt_s = ST_BURST;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Burst parameters, address advance and flush tracking.
  always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
    if (!emif_usr_reset_n) begin
      ready_en_r   <= 1'b0;
      flush_pend_r <= 1'b0;
      addr_r       <= ADDR_W'(BASE_ADDR);
      bcount_r     <= '0;
      beats_left_r <= '0;
    end else begin
      ready_en_r <= 1'b1;
      if (flush) begin
        flush_pend_r <= 1'b1;
      end else if (flush_done_s) begin
        flush_pend_r <= 1'b0;
      end
      if ((state_r == ST_IDLE) && start_s) begin
        bcount_r     <= BURSTCOUNT_W'(len_s);
        beats_left_r <= BURSTCOUNT_W'(len_s);
      end else if (pop_s) begin
        beats_left_r <= beats_left_r - BURSTCOUNT_W'(1);
        if (last_s) begin
          addr_r <= ADDR_W'(wrap_addr(32'(addr_r), 32'(bcount_r),
                                      32'(BASE_ADDR), 32'(REGION_WORDS)));
        end
      end
    end
  end

`ifdef DDR3_WR_BURST_STATS_EN
  // Free-running statistics counters.
  always_ff @(posedge emif_usr_clk or negedge emif_usr_reset_n) begin
    if (!emif_usr_reset_n) begin
      burst_cnt <= 32'd0;
      beat_cnt  <= 32'd0;
    end else begin
      if (last_s) burst_cnt <= burst_cnt + 32'd1;
      if (pop_s)  beat_cnt  <= beat_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr3_wr_burst_master.sv
// Scoreboard bench for ddr3_wr_burst_master (small region to force wraps):
// directed scenarios followed by randomized traffic, flushes and amm_ready.
module tb_ddr3_wr_burst_master;

  localparam int DW   = 320;
  localparam int AW   = 23;
  localparam int BL   = 32;
  localparam int FD   = 64;
  localparam int BASE = 0;
  localparam int REG  = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          flush = 1'b0;
  logic          flush_done, busy;
  logic          amm_ready = 1'b1;
  logic          amm_write;
  logic [AW-1:0] amm_address;
  logic [DW-1:0] amm_writedata;
  logic [6:0]    amm_burstcount;
  logic [DW/8-1:0] amm_byteenable;
`ifdef DDR3_WR_BURST_STATS_EN
  logic [31:0]   burst_cnt, beat_cnt;
`endif

  always #5 clk = ~clk;

  ddr3_wr_burst_master #(
    .DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .FIFO_DEPTH(FD),
    .BASE_ADDR(BASE), .REGION_WORDS(REG)
  ) dut (
    .emif_usr_clk(clk), .emif_usr_reset_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .flush(flush), .flush_done(flush_done), .busy(busy),
    .amm_ready(amm_ready), .amm_write(amm_write), .amm_address(amm_address),
    .amm_writedata(amm_writedata), .amm_burstcount(amm_burstcount),
`ifdef DDR3_WR_BURST_STATS_EN
    .burst_cnt(burst_cnt), .beat_cnt(beat_cnt),
`endif
    .amm_byteenable(amm_byteenable)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic check_data(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // ---------------- reference model / monitor ----------------
  logic [DW-1:0] q[$];
  int  addr_m = BASE, len_m = 0, baddr_m = 0, left_m = 0, last_len = 0;
  int  cyc = 0, lat_t = -1, cur_beats = 0, bursts_m = 0, beats_m = 0, fd_cnt = 0;
  bit  pend_m = 1'b0, rdy_m = 1'b0, prev_wr = 1'b0;

  always @(negedge clk) begin : mon
    int  lim, old;
    bit  fd_exp;
    logic [DW/8-1:0] be_ones;
    be_ones = '1;
    cyc++;
    if (!rst_n) begin
      q.delete();
      addr_m = BASE; pend_m = 1'b0; left_m = 0; rdy_m = 1'b0; prev_wr = 1'b0;
      lat_t = -1; cur_beats = 0; bursts_m = 0; beats_m = 0;
    end else begin
      check("s_ready", 64'(s_ready), 64'(rdy_m && !pend_m && (q.size() < FD)));
      check("busy", 64'(busy), 64'(q.size() > 0));
      fd_exp = pend_m && (q.size() == 0);
      check("flush_done", 64'(flush_done), 64'(fd_exp));
      if (flush_done) fd_cnt++;
      if (fd_exp) pend_m = 1'b0;
      if (lat_t == cyc) begin
        check("first_write_latency", 64'(amm_write), 64'd1);
        lat_t = -1;
      end else if (lat_t == cyc + 1) begin
        check("no_early_write", 64'(amm_write), 64'd0);
      end
      if (amm_write) begin
        if (left_m == 0) begin
          check("idle_gap", 64'(prev_wr), 64'd0);
          len_m = min2(BL, BASE + REG - addr_m);
          if (pend_m) len_m = min2(len_m, q.size());
          check("burst_fits_backlog", 64'((q.size() >= len_m) && (len_m > 0)), 64'd1);
          baddr_m = addr_m; left_m = len_m; cur_beats = 0; last_len = len_m;
        end
        check("amm_address", 64'(amm_address), 64'(baddr_m));
        check("amm_burstcount", 64'(amm_burstcount), 64'(len_m));
        check("amm_byteenable", 64'(amm_byteenable == be_ones), 64'd1);
        if (q.size() > 0) check_data("amm_writedata", amm_writedata, q[0]);
        if (amm_ready && (q.size() > 0)) begin
          void'(q.pop_front());
          left_m--; cur_beats++; beats_m++;
          if (left_m == 0) begin
            addr_m = addr_m + len_m;
            if (addr_m >= BASE + REG) addr_m = BASE;
            bursts_m++;
          end
        end
      end else if (left_m > 0) begin
        check("write_held_in_burst", 64'(amm_write), 64'd1);
      end
      if (s_valid && s_ready) begin
        old = q.size();
        q.push_back(s_data);
        lim = min2(BL, BASE + REG - addr_m);
        if (!amm_write && (left_m == 0) && (old < lim) && (q.size() >= lim)) lat_t = cyc + 2;
      end
      if (flush) pend_m = 1'b1;
      prev_wr = amm_write;
      rdy_m = 1'b1;
    end
  end

  // ---------------- amm_ready driver ----------------
  int rmode = 0;   // 0 always ready, 1 toggle, 2 random, 3 stalled
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       amm_ready = 1'b1;
      1:       amm_ready = ~amm_ready;
      2:       amm_ready = 1'($urandom_range(1, 0));
      default: amm_ready = 1'b0;
    endcase
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] rnd_beat();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic send(input int n, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      int  to;
      bit  acc;
      if ($urandom_range(99, 0) < gap_pct) begin
        s_valid = 1'b0;
        step();
      end
      s_valid = 1'b1;
      s_data  = rnd_beat();
      to = 0; acc = 1'b0;
      while (!acc && to < 5000) begin
        @(negedge clk); acc = s_ready;
        step();
        to++;
      end
      if (!acc) check("send_accept_timeout", 64'(acc), 64'd1);
    end
    s_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    bit ok;
    n = 0; ok = 1'b0;
    while (n < 4000 && !ok) begin
      @(negedge clk); #1;
      if (!busy && !pend_m && (left_m == 0) && (q.size() == 0)) ok = 1'b1;
      n++;
    end
    step();
    check(nm, 64'(ok), 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, f0, n, lowc;
    bit acc, hit;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_amm_write", 64'(amm_write), 64'd0);
    check("rst_amm_address", 64'(amm_address), 64'(BASE));
    check("rst_burstcount", 64'(amm_burstcount), 64'd0);
    check("rst_flush_done", 64'(flush_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single full burst at the base
    rmode = 0;
    send(32, 0);
    wait_idle("idle_after_first_burst");
    check("addr_after_first_burst", 64'(amm_address), 64'd32);
    check("first_burst_len", 64'(last_len), 64'd32);

    // toggling amm_ready: 8-beat burst to the region end, flush drains 24 at base
    rmode = 1; b0 = beats_m; f0 = fd_cnt;
    send(32, 0);
    repeat (60) step();
    pulse_flush();
    wait_idle("idle_after_toggle");
    check("toggle_beats", 64'(beats_m - b0), 64'd32);
    check("wrap_burst_len", 64'(last_len), 64'd24);
    check("toggle_flush_done_count", 64'(fd_cnt - f0), 64'd1);

    // short flush burst
    rmode = 0; f0 = fd_cnt;
    send(5, 0);
    repeat (5) step();
    pulse_flush();
    wait_idle("idle_after_flush5");
    check("flush5_len", 64'(last_len), 64'd5);
    check("flush5_done_count", 64'(fd_cnt - f0), 64'd1);

    // fill with the AMM side stalled
    rmode = 3; n = 0; lowc = 0;
    s_valid = 1'b1; s_data = rnd_beat();
    for (int i = 0; i < 300 && lowc < 5; i++) begin
      @(negedge clk); acc = s_ready;
      step();
      if (acc) begin n++; s_data = rnd_beat(); lowc = 0; end
      else lowc++;
    end
    s_valid = 1'b0;
    check("fill_until_full", 64'(n), 64'd64);
    rmode = 0;
    repeat (200) step();
    pulse_flush();
    wait_idle("idle_after_fill");

    // randomized traffic, flushes and backpressure
    for (int r = 0; r < 8; r++) begin
      rmode = 2;
      fork
        send($urandom_range(80, 1), 30);
        begin
          repeat ($urandom_range(120, 1)) step();
          if ($urandom_range(1, 0) == 1) pulse_flush();
        end
      join
    end
    pulse_flush();
    wait_idle("idle_after_random");

    // reset in the middle of a burst
    rmode = 0;
    send(32, 0);
    pulse_flush();
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk); #2;
      if (amm_write && cur_beats == 10) hit = 1'b1;
    end
    check("reached_beat_10", 64'(hit), 64'd1);
    rst_n = 1'b0;
    #1;
    check("reset_async_write", 64'(amm_write), 64'd0);
    check("reset_async_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_address", 64'(amm_address), 64'(BASE));
    check("post_reset_busy", 64'(busy), 64'd0);
    check("post_reset_s_ready_first", 64'(s_ready), 64'd0);
    @(negedge clk);
    check("post_reset_s_ready", 64'(s_ready), 64'd1);
    step();
    send(32, 0);
    wait_idle("idle_after_reset_burst");
    check("addr_after_reset_burst", 64'(amm_address), 64'd32);
`ifdef DDR3_WR_BURST_STATS_EN
    check("stats_burst_cnt", 64'(burst_cnt), 64'(bursts_m));
    check("stats_beat_cnt", 64'(beat_cnt), 64'(beats_m));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
